// File: rtl/relobi_pkg.sv
// Shared relobi types, default OBI config and index width helper.
package relobi_pkg;

  typedef struct packed {
    logic       UseRReady;
    logic [7:0] AddrWidth;
    logic [7:0] DataWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b0,
    AddrWidth: 8'd32,
    DataWidth: 8'd32
  };

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } relobi_a_chan_t;

  typedef struct packed {
    relobi_a_chan_t a;
    logic           req;
    logic           rready;
  } relobi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } relobi_r_chan_t;

  typedef struct packed {
    relobi_r_chan_t r;
    logic           gnt;
    logic           rvalid;
  } relobi_rsp_t;

  function automatic int unsigned
    relobi_err_sbr_arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relobi_err_sbr_arb_route_fifo.sv
// Route FIFO of manager indices; entries and pointers kept in three
// voted copies, any copy disagreement reported on fault.
module relobi_err_sbr_arb_route_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] data,
  output logic             fault
);

  localparam int unsigned PtrW =
    (Depth > 1) ? $clog2(Depth) : 1;

  // MSB is the wrap bit used to tell full from empty
  typedef logic [PtrW:0] ptr_t;

  ptr_t wr0_q, wr1_q, wr2_q;
  ptr_t rd0_q, rd1_q, rd2_q;
  ptr_t wr_v, rd_v, wr_nxt, rd_nxt;

  logic [Depth-1:0][Width-1:0] mem0_q;
  logic [Depth-1:0][Width-1:0] mem1_q;
  logic [Depth-1:0][Width-1:0] mem2_q;

  logic [Width-1:0] d0, d1, d2;
  logic [PtrW-1:0]  wr_idx, rd_idx;
  logic             do_push, do_pop;
  logic             ptr_mis, dat_mis;

  function automatic ptr_t vote(
    input ptr_t a, input ptr_t b, input ptr_t c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic ptr_t incr(input ptr_t p);
    ptr_t r;
    r = p;
    if (p[PtrW-1:0] == PtrW'(Depth - 1)) begin
      r[PtrW-1:0] = '0;
      r[PtrW]     = ~p[PtrW];
    end else begin
      r[PtrW-1:0] = p[PtrW-1:0] + 1'b1;
    end
    return r;
  endfunction

  assign wr_v   = vote(wr0_q, wr1_q, wr2_q);
  assign rd_v   = vote(rd0_q, rd1_q, rd2_q);
  assign wr_idx = wr_v[PtrW-1:0];
  assign rd_idx = rd_v[PtrW-1:0];

  assign empty = (wr_v == rd_v);
  assign full  = (wr_idx == rd_idx) &&
                 (wr_v[PtrW] != rd_v[PtrW]);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wr_nxt  = do_push ? incr(wr_v) : wr_v;
  assign rd_nxt  = do_pop ? incr(rd_v) : rd_v;

  assign d0   = mem0_q[rd_idx];
  assign d1   = mem1_q[rd_idx];
  assign d2   = mem2_q[rd_idx];
  assign data = (d0 & d1) | (d0 & d2) | (d1 & d2);

  assign ptr_mis = (wr0_q != wr1_q) | (wr1_q != wr2_q) |
                   (rd0_q != rd1_q) | (rd1_q != rd2_q);
  assign dat_mis = ~empty & ((d0 != d1) | (d1 != d2));
  assign fault   = ptr_mis | dat_mis;

  // Pointers rewritten from the voted value every cycle to scrub upsets
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr0_q  <= '0;
      wr1_q  <= '0;
      wr2_q  <= '0;
      rd0_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      mem0_q <= '0;
      mem1_q <= '0;
      mem2_q <= '0;
    end else begin
      wr0_q <= wr_nxt;
      wr1_q <= wr_nxt;
      wr2_q <= wr_nxt;
      rd0_q <= rd_nxt;
      rd1_q <= rd_nxt;
      rd2_q <= rd_nxt;
      if (do_push) begin
        mem0_q[wr_idx] <= data_in;
        mem1_q[wr_idx] <= data_in;
        mem2_q[wr_idx] <= data_in;
      end
    end
  end

endmodule

// File: rtl/relobi_err_sbr_arb.sv
// Round-robin share of one error subordinate among NumMgr managers.
// Optional fault counter: RELOBI_ERR_SBR_ARB_FAULT_CNT_EN.
module relobi_err_sbr_arb
  import relobi_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg      = ObiDefaultConfig,
  parameter type         obi_req_t   = relobi_req_t,
  parameter type         obi_rsp_t   = relobi_rsp_t,
  parameter int unsigned NumMgr      = 2,
  parameter int unsigned NumMaxTrans = 2
`ifdef RELOBI_ERR_SBR_ARB_FAULT_CNT_EN
  ,parameter int unsigned FaultCntW  = 8
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  obi_req_t   mgr_req_i [NumMgr],
  output obi_rsp_t   mgr_rsp_o [NumMgr],
  output obi_req_t   err_req_o,
  input  obi_rsp_t   err_rsp_i,
  input  logic [1:0] err_fault_i,
  output logic [1:0] fault_o
`ifdef RELOBI_ERR_SBR_ARB_FAULT_CNT_EN
  ,output logic [FaultCntW-1:0] fault_cnt_o
`endif
);

  localparam int unsigned IdxW =
    relobi_err_sbr_arb_idx_w(NumMgr);

  typedef logic [IdxW-1:0] idx_t;

  idx_t rr_ptr_q, lock_idx_q;
  idx_t rr_sel, cand, sel, head;
  logic lock_q, rr_valid;
  logic fwd, push, pop, rready;
  logic full, empty, fifo_fault, proto_err;

  always_comb begin
    rr_sel   = '0;
    rr_valid = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NumMgr; k++) begin
      cand = idx_t'((32'(rr_ptr_q) + k) % NumMgr);
      if (!rr_valid && mgr_req_i[cand].req) begin
        rr_valid = 1'b1;
        rr_sel   = cand;
      end
    end
  end

  // A forwarded but ungranted request pins the selection
  assign sel  = lock_q ? lock_idx_q : rr_sel;
  assign fwd  = mgr_req_i[sel].req & ~full;
  assign push = fwd & err_rsp_i.gnt;

  assign rready = ObiCfg.UseRReady ?
                  mgr_req_i[head].rready : 1'b1;
  assign pop       = err_rsp_i.rvalid & rready & ~empty;
  assign proto_err = err_rsp_i.rvalid & empty;

  always_comb begin
    err_req_o        = mgr_req_i[sel];
    err_req_o.req    = fwd;
    err_req_o.rready = rready;
  end

  always_comb begin
    for (int unsigned i = 0; i < NumMgr; i++) begin
      mgr_rsp_o[i]        = err_rsp_i;
      mgr_rsp_o[i].gnt    = push && (sel == idx_t'(i));
      mgr_rsp_o[i].rvalid = err_rsp_i.rvalid & ~empty &
                            (head == idx_t'(i));
    end
  end

  relobi_err_sbr_arb_route_fifo #(
    .Depth (NumMaxTrans),
    .Width (IdxW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (push),
    .pop     (pop),
    .data_in (sel),
    .full    (full),
    .empty   (empty),
    .data    (head),
    .fault   (fifo_fault)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (push) begin
      rr_ptr_q <= (32'(sel) == NumMgr - 1) ?
                  '0 : sel + idx_t'(1);
      lock_q   <= 1'b0;
    end else if (fwd) begin
      lock_q     <= 1'b1;
      lock_idx_q <= sel;
    end
  end

  assign fault_o = {
    err_fault_i[1],
    err_fault_i[0] | proto_err | fifo_fault
  };

`ifdef RELOBI_ERR_SBR_ARB_FAULT_CNT_EN
  logic [FaultCntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (|fault_o && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fault_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_relobi_err_sbr_arb.sv
// Scoreboard bench: directed stimulus queues expected grants and
// responses, a negedge monitor pops and compares them.
module tb_relobi_err_sbr_arb;
  import relobi_pkg::*;

  localparam obi_cfg_t TbCfg = '{
    UseRReady: 1'b1,
    AddrWidth: 8'd32,
    DataWidth: 8'd32
  };
  localparam logic [31:0] RData = 32'hBADCAB1E;

  typedef struct {
    int          idx;
    logic [31:0] addr;
  } gexp_t;

  logic        clk;
  logic        rst_n;
  relobi_req_t mgr_req [2];
  relobi_rsp_t mgr_rsp [2];
  relobi_req_t err_req;
  relobi_rsp_t err_rsp;
  logic [1:0]  err_fault;
  logic [1:0]  fault;
`ifdef RELOBI_ERR_SBR_ARB_FAULT_CNT_EN
  logic [7:0]  fault_cnt;
`endif

  gexp_t gq[$];
  int    rq[$];
  int    n_cmp;
  int    n_bad;

  relobi_err_sbr_arb #(
    .ObiCfg      (TbCfg),
    .obi_req_t   (relobi_req_t),
    .obi_rsp_t   (relobi_rsp_t),
    .NumMgr      (2),
    .NumMaxTrans (2)
`ifdef RELOBI_ERR_SBR_ARB_FAULT_CNT_EN
    ,.FaultCntW  (8)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mgr_req_i   (mgr_req),
    .mgr_rsp_o   (mgr_rsp),
    .err_req_o   (err_req),
    .err_rsp_i   (err_rsp),
    .err_fault_i (err_fault),
    .fault_o     (fault)
`ifdef RELOBI_ERR_SBR_ARB_FAULT_CNT_EN
    ,.fault_cnt_o (fault_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i * 4);
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      mgr_req[i].req    = 1'b0;
      mgr_req[i].rready = 1'b1;
    end
    err_rsp.gnt    = 1'b0;
    err_rsp.rvalid = 1'b0;
    err_fault      = 2'b00;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (mgr_rsp[i].gnt) begin
          n_cmp++;
          if (gq.size() == 0) begin
            n_bad++;
            $display("FAIL gnt_unexp got=mgr%0d exp=none", i);
          end else begin
            gexp_t e;
            e = gq.pop_front();
            if (e.idx != i || err_req.a.addr !== e.addr) begin
              n_bad++;
              $display("FAIL gnt got=mgr%0d/%0h exp=mgr%0d/%0h",
                       i, err_req.a.addr, e.idx, e.addr);
            end
          end
        end
        if (mgr_rsp[i].rvalid && mgr_req[i].rready) begin
          n_cmp++;
          if (rq.size() == 0) begin
            n_bad++;
            $display("FAIL rvalid_unexp got=mgr%0d exp=none", i);
          end else begin
            int e;
            e = rq.pop_front();
            if (e != i || mgr_rsp[i].r.rdata !== RData ||
                mgr_rsp[i].r.err !== 1'b1) begin
              n_bad++;
              $display("FAIL rsp got=mgr%0d/%0h/%0b exp=mgr%0d/%0h/1",
                       i, mgr_rsp[i].r.rdata, mgr_rsp[i].r.err,
                       e, RData);
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mgr_req[i]        = '0;
      mgr_req[i].a.addr = addr_of(i);
      mgr_req[i].a.aid  = 4'(i);
    end
    err_rsp         = '0;
    err_rsp.r.rdata = RData;
    err_rsp.r.err   = 1'b1;
    idle();
    nxt();
    nxt();
    neg();
    chk("rst_req", 64'(err_req.req), 64'd0);
    chk("rst_gnt", 64'({mgr_rsp[1].gnt, mgr_rsp[0].gnt}), 64'd0);
    chk("rst_rv",
        64'({mgr_rsp[1].rvalid, mgr_rsp[0].rvalid}), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    nxt();
    rst_n = 1'b1;

    // 1: both request, always granted -> 0,1,0
    nxt();
    mgr_req[0].req = 1'b1;
    mgr_req[1].req = 1'b1;
    err_rsp.gnt    = 1'b1;
    gq.push_back('{0, addr_of(0)});
    neg();
    chk("t1_req", 64'(err_req.req), 64'd1);
    nxt();
    gq.push_back('{1, addr_of(1)});
    err_rsp.rvalid = 1'b1;
    rq.push_back(0);
    nxt();
    gq.push_back('{0, addr_of(0)});
    rq.push_back(1);
    neg();
    chk("t1_bcast", 64'(mgr_rsp[0].r.rdata), 64'(RData));
    nxt();
    mgr_req[0].req = 1'b0;
    mgr_req[1].req = 1'b0;
    rq.push_back(0);
    nxt();
    idle();
    do_reset();

    // 2: lock holds mgr1 while gnt low
    nxt();
    mgr_req[1].req = 1'b1;
    neg();
    chk("t2_req", 64'(err_req.req), 64'd1);
    chk("t2_a0", 64'(err_req.a.addr), 64'(addr_of(1)));
    nxt();
    neg();
    chk("t2_a1", 64'(err_req.a.addr), 64'(addr_of(1)));
    nxt();
    mgr_req[0].req = 1'b1;
    neg();
    chk("t2_lock", 64'(err_req.a.addr), 64'(addr_of(1)));
    nxt();
    err_rsp.gnt = 1'b1;
    gq.push_back('{1, addr_of(1)});
    nxt();
    mgr_req[1].req = 1'b0;
    gq.push_back('{0, addr_of(0)});
    nxt();
    mgr_req[0].req = 1'b0;
    err_rsp.gnt    = 1'b0;
    err_rsp.rvalid = 1'b1;
    rq.push_back(1);
    nxt();
    rq.push_back(0);
    nxt();
    idle();

    // 3: rready low fills FIFO, one pop frees one slot
    mgr_req[0].rready = 1'b0;
    mgr_req[1].rready = 1'b0;
    nxt();
    mgr_req[0].req = 1'b1;
    mgr_req[1].req = 1'b1;
    err_rsp.gnt    = 1'b1;
    gq.push_back('{1, addr_of(1)});
    nxt();
    gq.push_back('{0, addr_of(0)});
    nxt();
    neg();
    chk("t3_full_req", 64'(err_req.req), 64'd0);
    chk("t3_full_gnt",
        64'({mgr_rsp[1].gnt, mgr_rsp[0].gnt}), 64'd0);
    chk("t3_rready", 64'(err_req.rready), 64'd0);
    nxt();
    err_rsp.rvalid    = 1'b1;
    mgr_req[1].rready = 1'b1;
    rq.push_back(1);
    neg();
    chk("t3_nofall", 64'(err_req.req), 64'd0);
    chk("t3_rready1", 64'(err_req.rready), 64'd1);
    nxt();
    err_rsp.rvalid = 1'b0;
    gq.push_back('{1, addr_of(1)});
    nxt();
    mgr_req[0].req    = 1'b0;
    mgr_req[1].req    = 1'b0;
    err_rsp.gnt       = 1'b0;
    mgr_req[0].rready = 1'b1;
    err_rsp.rvalid    = 1'b1;
    rq.push_back(0);
    nxt();
    rq.push_back(1);
    nxt();
    idle();

    // 4: stray response with empty FIFO
    nxt();
    err_rsp.rvalid = 1'b1;
    neg();
    chk("t4_proto", 64'(fault), 64'd1);
    nxt();
    err_rsp.rvalid = 1'b0;
    neg();
    chk("t4_clear", 64'(fault), 64'd0);

    // 5: corrupt one TMR copy, routing must survive
    nxt();
    mgr_req[1].req = 1'b1;
    err_rsp.gnt    = 1'b1;
    gq.push_back('{1, addr_of(1)});
    nxt();
    idle();
    force dut.u_fifo.mem1_q = '0;
    neg();
    chk("t5_tmr", 64'(fault), 64'd1);
    nxt();
    err_rsp.rvalid = 1'b1;
    rq.push_back(1);
    neg();
    chk("t5_tmr_pop", 64'(fault), 64'd1);
    nxt();
    err_rsp.rvalid = 1'b0;
    release dut.u_fifo.mem1_q;
    neg();
    chk("t5_empty", 64'(fault), 64'd0);
    nxt();
    err_fault = 2'b10;
    neg();
    chk("t5_unc", 64'(fault), 64'd2);
    nxt();
    err_fault = 2'b00;

    // 7: reset with a route outstanding
    nxt();
    mgr_req[0].req = 1'b1;
    err_rsp.gnt    = 1'b1;
    gq.push_back('{0, addr_of(0)});
    nxt();
    idle();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();
    err_rsp.rvalid = 1'b1;
    neg();
    chk("t7_late", 64'(fault), 64'd1);
    nxt();
    err_rsp.rvalid = 1'b0;

`ifdef RELOBI_ERR_SBR_ARB_FAULT_CNT_EN
    // 6: saturating counter and reset mid-burst
    do_reset();
    nxt();
    err_fault = 2'b01;
    repeat (10) nxt();
    neg();
    chk("t6_cnt10", 64'(fault_cnt), 64'd10);
    repeat (290) nxt();
    neg();
    chk("t6_sat", 64'(fault_cnt), 64'd255);
    nxt();
    err_fault = 2'b00;
    rst_n     = 1'b0;
    nxt();
    neg();
    chk("t6_rst_cnt", 64'(fault_cnt), 64'd0);
    chk("t6_rst_fault", 64'(fault), 64'd0);
    chk("t6_rst_req", 64'(err_req.req), 64'd0);
    rst_n = 1'b1;
`endif

    nxt();
    nxt();
    chk("gq_drained", 64'(gq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
